// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, buffer entry layout,
// the decode bubble instruction and word-address helpers.
package fetch_unit_pkg;

    // Bus-side request state of the fetch stage
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,  // no request in flight
        ST_REQ     = 2'b01,  // request in flight, result will be kept
        ST_DISCARD = 2'b10   // request in flight, result will be dropped
    } fetch_state_t;

    // One instruction buffer entry: fetch address plus instruction word
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0 -- used by decode to insert bubbles
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Address of the following word, wrapping modulo 2^32
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + WORD_BYTES;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer between fetch and decode. Power-of-two depth so the
// read/write pointers wrap naturally. Clear wins over push and pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t         mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push_eff;
    logic                 pop_eff;

    // Qualify push/pop: a clear cancels both, and an empty buffer cannot pop
    always_comb begin
        push_eff = push & ~clear;
        pop_eff  = pop & ~clear & (count_q != '0);
    end

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads at the current PC, advances the
// PC on each completed read, buffers {pc, instr} for decode and handles
// redirects even while a read is outstanding on the bus.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_load,
    output logic [31:0] pc_next,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic             mem_rd_q, mem_rd_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_wdata;
    fetch_entry_t     fifo_rdata;
    logic             ack;
    logic             has_room;
    logic             issue;
    logic             fifo_push;
    logic             fifo_pop;

    // A read completes only while we are actually requesting. A new request
    // is only started when the buffer has a free slot, so a push can never
    // hit a full buffer.
    always_comb begin
        ack      = mem_rd_q & mem_ack;
        has_room = fifo_count < CNT_W'(FIFO_DEPTH);
        issue    = (state_q == ST_IDLE) & ~flush & has_room;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a flush during an unacked request must still wait out
    // the bus transaction, hence DISCARD rather than abandoning it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack)        state_d = ST_IDLE;
                else if (flush) state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: PC update, buffer push/pop and the next bus request
    always_comb begin
        pc_load    = 1'b0;
        pc_next    = next_word(mem_addr_q);
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;

        if (flush) begin
            pc_load = 1'b1;
            pc_next = flush_target;
        end else begin
            if ((state_q == ST_REQ) && ack) begin
                pc_load   = 1'b1;
                fifo_push = 1'b1;
            end
            fifo_pop = instr_valid & instr_ready;
        end

        // Address stays frozen for the whole life of a request
        if (issue) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = word_align(pc);
        end else if (ack) begin
            mem_rd_d   = 1'b0;
        end

        // The PC register is being reset alongside us; never load it then
        if (reset) begin
            pc_load = 1'b0;
        end
    end

    // Bus request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= BOOT_ADDRESS;
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign fifo_wdata = '{pc: mem_addr_q, instr: mem_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (fifo_count != '0);
    // Present a bubble rather than stale storage when nothing is buffered
    assign instr_out   = instr_valid ? fifo_rdata.instr : NOP_INSTR;
    assign instr_pc    = fifo_rdata.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the Risco-5 core. Sits directly downstream of the program counter register: it reads the current PC, issues word reads on the instruction memory port, drives the PC's load/next-value inputs, and buffers fetched instructions with their addresses in a small FIFO for decode. It handles branch/jump redirects (flush) while a memory read is still in flight.

## Interface
- `BOOT_ADDRESS`, default 32'h00000000: reset value of `mem_addr`. Must match the PC's boot address.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Power of two, at least 2.

- `clk`  in  1  sole clock; everything updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  32  current PC register value.
- `pc_load`  out  1  combinational; PC load enable.
- `pc_next`  out  32  combinational; PC load value.
- `flush`  in  1  redirect request from execute.
- `flush_target`  in  32  redirect address, valid while `flush` is high.
- `mem_rd`  out  1  registered; read request.
- `mem_addr`  out  32  registered; word address, bits [1:0] always 0.
- `mem_ack`  in  1  read completes in any cycle where `mem_rd` and `mem_ack` are both high.
- `mem_data`  in  32  read data, valid with `mem_ack`.
- `instr_valid`  out  1  FIFO non-empty.
- `instr_ready`  in  1  decode accepts the head entry.
- `instr_out`  out  32  head instruction.
- `instr_pc`  out  32  address of the head instruction.

## Operation
- FSM states: IDLE (no request in flight), REQ (request in flight, result kept), DISCARD (request in flight, result dropped).
- Issue rule: in IDLE, when `flush` is low and `count < FIFO_DEPTH`, at the next edge set `mem_rd`=1, `mem_addr`={pc[31:2],2'b00} and go to REQ.
- REQ with `mem_ack`=1 and no flush:
  - push {`mem_addr`, `mem_data`} into the FIFO.
  - clear `mem_rd`; go to IDLE.
  - same cycle, combinationally: `pc_load`=1, `pc_next`=`mem_addr`+4.
- Flush always has priority. In the flush cycle:
  - `pc_load`=1, `pc_next`=`flush_target`.
  - At the edge, the FIFO empties (count=0) and any simultaneous push or pop is ignored.
  - IDLE → IDLE. REQ with ack → IDLE, data dropped. REQ without ack → DISCARD.
- DISCARD: hold `mem_rd`=1 and the old `mem_addr` until `mem_ack`, drop the data, go to IDLE, and do not load the PC. A further flush while in DISCARD only reloads the PC. Requests are never abandoned on the bus.
- While `mem_rd`=1, `mem_addr` is stable.
- FIFO:
  - Pop on `instr_valid & instr_ready`.
  - Simultaneous push and pop keeps the count unchanged.
  - Push at full cannot occur, because the issue rule reserves the slot.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Address arithmetic is 32-bit modulo. 32'hFFFFFFFC + 4 wraps to 0.
- Outside the ack and flush cases, `pc_load`=0.

## Timing
- Reset values: `mem_rd`=0, `mem_addr`=`BOOT_ADDRESS`, FIFO empty (`instr_valid`=0), state IDLE. `instr_out` and `instr_pc` are don't-care while `instr_valid`=0. `pc_load`=0 during reset.
- Reset mid-request drops the in-flight request. The memory must tolerate this.
- First request: `mem_rd` rises at the first edge after `reset` falls.
- Zero-wait memory (ack in the first `mem_rd` cycle) gives one instruction every 2 cycles.
- Latency: an entry is visible on `instr_valid` the cycle after its ack.
- Redirect: the target is fetched with `mem_rd` asserted 1 cycle after the flush cycle if idle, or 1 cycle after the discarded ack.

## Structure
- Shared core header/localparams: FSM state encoding (2 bits) and NOP constant 32'h00000013 (used by decode for bubbles).
- Sub-module `fetch_fifo`: parameterised depth, 64-bit entries {pc, instr}, with `push`, `pop` and `clear` inputs and a `count` output.

## Test plan
- Reset with `BOOT_ADDRESS`=32'h00000100, zero-wait memory, `instr_ready`=1 → `mem_addr` sequence 0x100, 0x104, 0x108; `instr_pc` matches each; `mem_rd` high on alternate cycles.
- `instr_ready`=0, `FIFO_DEPTH`=2 → exactly two acks, then `mem_rd` stays 0. Raise `instr_ready` for 1 cycle → one pop, one new request.
- Memory with 3 wait states → `mem_rd` and `mem_addr` stable for 4 cycles. Entry appears the cycle after the ack.
- Flush to 0x200 while REQ to 0x10C is unacked → `pc_next`=0x200 and FIFO empty in the next cycle. Ack for 0x10C is dropped (no push, `pc_load`=0). Next request is to 0x200.
- Flush coincident with `mem_ack` and `instr_ready` → no push, no pop effect, count 0, state IDLE, `pc_next`=`flush_target`.
- `pc`=32'hFFFFFFFC acked → `pc_next`=32'h00000000.
